board_row_streamer: RTL and testbench

//  Writer end of the board-row update interface: owns the authoritative ROWSxCOLS cell grid written by game logic and

---
 rtl/board_pkg.sv | 26 ++
 rtl/dirty_row_picker.sv | 24 ++
 rtl/board_row_streamer.sv | 123 ++++++++++++
 tb/tb_board_row_streamer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants and types for the board-row streaming link.
package board_pkg;
    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int CELL_W = 3;
    localparam int IDX_W  = 5;
    localparam int COL_W  = 4;
    localparam int ROW_W  = COLS * CELL_W;

    localparam logic [IDX_W-1:0] ROWS_IDX   = IDX_W'(ROWS);
    localparam logic [COL_W-1:0] COLS_IDX   = COL_W'(COLS);
    localparam logic [IDX_W-1:0] IDLE_INDEX = '0;

    typedef logic [CELL_W-1:0] cell_t;
    typedef logic [ROW_W-1:0]  row_t;

    typedef enum logic [1:0] {IDLE, SEND, DONE} stream_state_t;

    // Number of set bits in a per-row flag vector.
    function automatic logic [IDX_W-1:0] popcount(input logic [ROWS-1:0] v);
        logic [IDX_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ROWS; i++) cnt = cnt + IDX_W'(v[i]);
        return cnt;
    endfunction
endpackage

// File: rtl/dirty_row_picker.sv
// Lowest dirty row at or above the scan pointer.
module dirty_row_picker
    import board_pkg::*;
(
    input  logic [ROWS-1:0]  dirty_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] row_o
);
    logic [ROWS-1:0] masked;

    // Drop rows below ptr, then priority-encode from the bottom up.
    always_comb begin
        masked  = dirty_i & ~((ROWS'(1) << ptr_i) - ROWS'(1));
        found_o = 1'b0;
        row_o   = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (masked[r]) begin
                found_o = 1'b1;
                row_o   = IDX_W'(r);
            end
        end
    end
endmodule

// File: rtl/board_row_streamer.sv
// Owns the cell grid and streams dirty rows to the renderer during blanking.
module board_row_streamer
    import board_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cell_we,
    input  logic [4:0]  cell_row,
    input  logic [3:0]  cell_col,
    input  logic [2:0]  cell_val,
    input  logic        full_refresh,
    input  logic        frame_start,
    input  logic        blank_end,
    output logic [29:0] row_data,
    output logic [4:0]  row_index,
    output logic        busy,
    output logic [4:0]  dirty_cnt
);
    row_t            grid_q [ROWS];
    row_t            grid_d [ROWS];
    logic [ROWS-1:0] dirty_q, dirty_d;
    logic [IDX_W-1:0] dirty_cnt_q;
    stream_state_t   state_q;
    logic [IDX_W-1:0] ptr_q, scan_ptr;
    row_t            row_data_q, emit_row;
    logic [IDX_W-1:0] row_index_q;
    logic            busy_q;
    logic            found, wr_ok, emit;
    logic [IDX_W-1:0] pick;

    assign wr_ok    = cell_we && (cell_row < ROWS_IDX) && (cell_col < COLS_IDX);
    // A frame_start arriving mid-burst rescans from the top in that same cycle.
    assign scan_ptr = (state_q == SEND && frame_start) ? '0 : ptr_q;
    assign emit     = (state_q == SEND) && !blank_end && found;

    dirty_row_picker u_picker (
        .dirty_i (dirty_q),
        .ptr_i   (scan_ptr),
        .found_o (found),
        .row_o   (pick)
    );

    // Next grid/dirty state: emission clears first, writes and refresh set after, so set wins.
    always_comb begin
        grid_d  = grid_q;
        dirty_d = dirty_q;
        for (int r = 0; r < ROWS; r++) begin
            if (emit && pick == IDX_W'(r)) dirty_d[r] = 1'b0;
            for (int c = 0; c < COLS; c++) begin
                if (wr_ok && cell_row == IDX_W'(r) && cell_col == COL_W'(c)) begin
                    grid_d[r][c*CELL_W +: CELL_W] = cell_val;
                    dirty_d[r] = 1'b1;
                end
            end
        end
        if (full_refresh) dirty_d = '1;
    end

    // Emitted row carries any write landing on the same edge.
    always_comb begin
        emit_row = '0;
        for (int r = 0; r < ROWS; r++)
            if (pick == IDX_W'(r)) emit_row = grid_d[r];
    end

    // Grid, dirty flags and dirty count; reset dirties every row so the first frame paints a blank board.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
            dirty_q     <= '1;
            dirty_cnt_q <= ROWS_IDX;
        end else begin
            grid_q      <= grid_d;
            dirty_q     <= dirty_d;
            dirty_cnt_q <= popcount(dirty_d);
        end
    end

    // Stream FSM with registered link outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            row_data_q  <= '0;
            row_index_q <= IDLE_INDEX;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    row_index_q <= IDLE_INDEX;
                    busy_q      <= 1'b0;
                    if (frame_start) begin
                        state_q <= SEND;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (emit) begin
                        row_data_q  <= emit_row;
                        row_index_q <= pick + IDX_W'(1);
                        ptr_q       <= pick + IDX_W'(1);
                    end else begin
                        state_q     <= DONE;
                        row_index_q <= IDLE_INDEX;
                        busy_q      <= 1'b0;
                    end
                end
                DONE: begin
                    row_index_q <= IDLE_INDEX;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_data  = row_data_q;
    assign row_index = row_index_q;
    assign busy      = busy_q;
    assign dirty_cnt = dirty_cnt_q;
endmodule

// File: tb/tb_board_row_streamer.sv
// Bench for board_row_streamer: cell-write vector table plus multi-cycle sequences, link words checked by a scoreboard.
module tb_board_row_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cell_we = 1'b0;
    logic [4:0]  cell_row = '0;
    logic [3:0]  cell_col = '0;
    logic [2:0]  cell_val = '0;
    logic        full_refresh = 1'b0;
    logic        frame_start = 1'b0;
    logic        blank_end = 1'b0;
    logic [29:0] row_data;
    logic [4:0]  row_index;
    logic        busy;
    logic [4:0]  dirty_cnt;

    typedef struct {
        logic [4:0]  idx;
        logic [29:0] data;
    } word_t;

    typedef struct {
        logic [4:0]  r;
        logic [3:0]  c;
        logic [2:0]  v;
        logic [4:0]  exp_idx;
        logic [29:0] exp_data;
    } vec_t;

    word_t       sbq[$];
    logic [29:0] mg [20];
    int          n_checks = 0;
    int          n_fail = 0;

    board_row_streamer dut (
        .clk          (clk),
        .rst          (rst),
        .cell_we      (cell_we),
        .cell_row     (cell_row),
        .cell_col     (cell_col),
        .cell_val     (cell_val),
        .full_refresh (full_refresh),
        .frame_start  (frame_start),
        .blank_end    (blank_end),
        .row_data     (row_data),
        .row_index    (row_index),
        .busy         (busy),
        .dirty_cnt    (dirty_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every non-idle word on the link must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && row_index != 5'd0) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got index %0d data 0x%0h, expected none", row_index, row_data);
            end else begin
                word_t w;
                w = sbq.pop_front();
                check("word_index", {27'd0, row_index}, {27'd0, w.idx});
                check("word_data", {2'd0, row_data}, {2'd0, w.data});
            end
        end
    end

    task automatic wr(input logic [4:0] r, input logic [3:0] c, input logic [2:0] v);
        cell_we = 1'b1; cell_row = r; cell_col = c; cell_val = v;
        if (r < 20 && c < 10) mg[r][c*3 +: 3] = v;
        @(negedge clk);
        cell_we = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic push_row(input int r);
        word_t w;
        w.idx  = 5'(r + 1);
        w.data = mg[r];
        sbq.push_back(w);
    endtask

    task automatic push_all();
        for (int r = 0; r < 20; r++) push_row(r);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, k);
        end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, sbq.size(), 0);
    endtask

    initial begin
        vec_t vt[8];
        vt[0] = '{5'd5,  4'd2,  3'd3, 5'd6,  30'h0000_00C0};
        vt[1] = '{5'd5,  4'd9,  3'd7, 5'd6,  30'h3800_00C0};
        vt[2] = '{5'd0,  4'd0,  3'd1, 5'd1,  30'h0000_0001};
        vt[3] = '{5'd19, 4'd4,  3'd5, 5'd20, 30'h0000_5000};
        vt[4] = '{5'd20, 4'd0,  3'd7, 5'd0,  30'h0};
        vt[5] = '{5'd3,  4'd10, 3'd7, 5'd0,  30'h0};
        vt[6] = '{5'd5,  4'd2,  3'd0, 5'd6,  30'h3800_0000};
        vt[7] = '{5'd12, 4'd15, 3'd2, 5'd0,  30'h0};

        for (int r = 0; r < 20; r++) mg[r] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_row_index", row_index, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_row_index", row_index, 0);
        check("rst_row_data", row_data, 0);
        check("rst_busy", busy, 0);
        check("rst_dirty_cnt", dirty_cnt, 20);

        // First frame paints every row blank, one per cycle
        push_all();
        pulse_frame();
        check("first_lat_idle", row_index, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("first_burst_index", row_index, i);
        end
        @(negedge clk);
        check("first_burst_end", row_index, 0);
        wait_idle("first_frame");
        check("first_dirty_cnt", dirty_cnt, 0);

        // Single-cell write vectors, each followed by one frame
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].r, vt[i].c, vt[i].v);
            if (vt[i].exp_idx != 0) begin
                word_t w;
                w.idx = vt[i].exp_idx;
                w.data = vt[i].exp_data;
                sbq.push_back(w);
                check("vec_dirty_cnt", dirty_cnt, 1);
            end else begin
                check("vec_oor_dirty_cnt", dirty_cnt, 0);
            end
            pulse_frame();
            wait_idle("vec");
            check("vec_clean", dirty_cnt, 0);
        end

        // blank_end cuts the burst after row 3
        wr(5'd3, 4'd1, 3'd2);
        wr(5'd17, 4'd0, 3'd4);
        push_row(3);
        pulse_frame();
        @(negedge clk);
        check("blank_row3_sent", row_index, 4);
        blank_end = 1'b1;
        @(negedge clk);
        blank_end = 1'b0;
        check("blank_no_row17", row_index, 0);
        wait_idle("blank_cut");
        check("blank_dirty_cnt", dirty_cnt, 1);
        push_row(17);
        pulse_frame();
        wait_idle("blank_next");
        check("blank_next_clean", dirty_cnt, 0);

        // Write to row 7 on the cycle it is picked
        wr(5'd7, 4'd0, 3'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cell_we = 1'b1; cell_row = 5'd7; cell_col = 4'd5; cell_val = 3'd6;
        mg[7][15 +: 3] = 3'd6;
        push_row(7);
        @(negedge clk);
        cell_we = 1'b0;
        wait_idle("collide");
        check("collide_still_dirty", dirty_cnt, 1);
        push_row(7);
        pulse_frame();
        wait_idle("collide_resend");
        check("collide_clean", dirty_cnt, 0);

        // full_refresh with a same-cycle write
        full_refresh = 1'b1;
        wr(5'd0, 4'd9, 3'd7);
        full_refresh = 1'b0;
        check("refresh_dirty_cnt", dirty_cnt, 20);
        check("refresh_model_top", {29'd0, mg[0][29:27]}, 32'd7);
        push_all();
        pulse_frame();
        wait_idle("refresh");

        // Reset in the middle of a burst
        full_refresh = 1'b1;
        @(negedge clk);
        full_refresh = 1'b0;
        push_all();
        pulse_frame();
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("midrst_index", row_index, 0);
        check("midrst_busy", busy, 0);
        sbq.delete();
        for (int r = 0; r < 20; r++) mg[r] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dirty_cnt", dirty_cnt, 20);
        check("midrst_row_data", row_data, 0);
        push_all();
        pulse_frame();
        wait_idle("midrst_resend");
        check("midrst_clean", dirty_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
